// File: rtl/noc_pkg.sv
// noc_pkg: shared NoC flit types, packet geometry and arbiter states.
// Imported by the wormhole arbiter and its round-robin sub-block.
package noc_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int PACKET_LEN = 6;
  localparam int DEST_LSB   = 0;
  localparam int DEST_MSB   = 3;

  typedef logic [DATA_WIDTH-1:0] flit_t;

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  // Destination field of a head flit.
  function automatic logic [DEST_MSB-DEST_LSB:0] flit_dest(flit_t f);
    return f[DEST_MSB:DEST_LSB];
  endfunction

endpackage

// File: rtl/noc_wormhole_arbiter_if.sv
// noc_wormhole_arbiter_if: requester flits in, one flit channel out.
// slave = arbiter side, master = requesters plus downstream stage.
interface noc_wormhole_arbiter_if #(
  parameter int NUM_INPUTS = 4,
  parameter int DATA_WIDTH = 32
);

  localparam int GRANT_W = $clog2(NUM_INPUTS);

  logic [NUM_INPUTS*DATA_WIDTH-1:0] data_in;
  logic [NUM_INPUTS-1:0]            valid_in;
  logic [NUM_INPUTS-1:0]            ready_in;
  logic [DATA_WIDTH-1:0]            data_out;
  logic                             valid_out;
  logic                             ready_out;
  logic                             grant_valid;
  logic [GRANT_W-1:0]               grant_idx;
  logic [15:0]                      packets_sent;

  modport slave (
    input  data_in,
    input  valid_in,
    input  ready_out,
    output ready_in,
    output data_out,
    output valid_out,
    output grant_valid,
    output grant_idx,
    output packets_sent
  );

  modport master (
    output data_in,
    output valid_in,
    output ready_out,
    input  ready_in,
    input  data_out,
    input  valid_out,
    input  grant_valid,
    input  grant_idx,
    input  packets_sent
  );

endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first req at/after ptr.
// Ports: req, ptr in; any (some req set), idx (chosen requester) out.
module rr_arbiter #(
  parameter int NUM_INPUTS = 4,
  localparam int GRANT_W = $clog2(NUM_INPUTS)
) (
  input  logic [NUM_INPUTS-1:0] req,
  input  logic [GRANT_W-1:0]    ptr,
  output logic                  any,
  output logic [GRANT_W-1:0]    idx
);

  localparam int SW = GRANT_W + 1;

  logic [NUM_INPUTS-1:0] rot;
  logic                  found;
  logic [SW-1:0]         sum;

  // Rotating the doubled vector puts ptr at bit 0, so the first
  // set bit is the winner's distance from ptr.
  always_comb begin
    rot   = NUM_INPUTS'({req, req} >> ptr);
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        sum   = {1'b0, ptr} + SW'(i);
      end
    end
    if (sum >= SW'(NUM_INPUTS))
      idx = GRANT_W'(sum - SW'(NUM_INPUTS));
    else
      idx = sum[GRANT_W-1:0];
    any = |req;
  end

endmodule

// File: rtl/noc_wormhole_arbiter.sv
// noc_wormhole_arbiter: round-robin flit channel with wormhole locking.
// Ports: clk, rst (async, high); bus = requester/downstream channel.
module noc_wormhole_arbiter #(
  parameter int NUM_INPUTS = 4,
  parameter int DATA_WIDTH = noc_pkg::DATA_WIDTH,
  parameter int PACKET_LEN = noc_pkg::PACKET_LEN
) (
  input logic                    clk,
  input logic                    rst,
  noc_wormhole_arbiter_if.slave  bus
);

  import noc_pkg::*;

  localparam int GRANT_W = $clog2(NUM_INPUTS);
  localparam int CNT_W   = $clog2(PACKET_LEN);

  state_t                state;
  logic [GRANT_W-1:0]    rr_ptr;
  logic [GRANT_W-1:0]    grant_idx;
  logic [GRANT_W-1:0]    next_ptr;
  logic [GRANT_W-1:0]    arb_idx;
  logic                  arb_any;
  logic [CNT_W-1:0]      flit_cnt;
  logic                  grant_valid;
  logic [15:0]           packets_sent;
  logic [NUM_INPUTS-1:0] grant_oh;
  logic [DATA_WIDTH-1:0] sel_flit;
  logic                  locked;
  logic                  xfer;
  logic                  last;

  rr_arbiter #(
    .NUM_INPUTS (NUM_INPUTS)
  ) u_rr (
    .req (bus.valid_in),
    .ptr (rr_ptr),
    .any (arb_any),
    .idx (arb_idx)
  );

  always_comb begin
    grant_oh = '0;
    sel_flit = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (grant_idx == GRANT_W'(i)) begin
        grant_oh[i] = 1'b1;
        sel_flit    = bus.data_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    next_ptr = grant_idx + GRANT_W'(1);
    if (grant_idx == GRANT_W'(NUM_INPUTS-1))
      next_ptr = '0;
  end

  assign locked = (state == LOCKED);
  assign last   = (flit_cnt == CNT_W'(PACKET_LEN-1));
  assign xfer   = bus.valid_out & bus.ready_out;

  // ready_in never looks at valid_in: lock state and ready_out only.
  assign bus.ready_in  = locked ?
    (grant_oh & {NUM_INPUTS{bus.ready_out}}) : '0;
  assign bus.valid_out = locked & |(bus.valid_in & grant_oh);
  assign bus.data_out  = bus.valid_out ? sel_flit : '0;

  assign bus.grant_valid  = grant_valid;
  assign bus.grant_idx    = grant_idx;
  assign bus.packets_sent = packets_sent;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      flit_cnt     <= '0;
      grant_idx    <= '0;
      grant_valid  <= 1'b0;
      packets_sent <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (arb_any) begin
            grant_idx   <= arb_idx;
            grant_valid <= 1'b1;
            flit_cnt    <= '0;
            state       <= LOCKED;
          end
        end
        LOCKED: begin
          if (xfer) begin
            if (last) begin
              rr_ptr       <= next_ptr;
              packets_sent <= packets_sent + 16'd1;
              flit_cnt     <= '0;
              grant_valid  <= 1'b0;
              grant_idx    <= '0;
              state        <= IDLE;
            end else begin
              flit_cnt <= flit_cnt + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_noc_wormhole_arbiter.sv
// tb_noc_wormhole_arbiter: directed tests for the wormhole arbiter.
// Drives and samples on the falling edge; expectations are hand-tabled.
module tb_noc_wormhole_arbiter;

  import noc_pkg::*;

  localparam int N  = 4;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  noc_wormhole_arbiter_if #(
    .NUM_INPUTS (N),
    .DATA_WIDTH (DW)
  ) bus ();

  noc_wormhole_arbiter #(
    .NUM_INPUTS (N),
    .DATA_WIDTH (DW),
    .PACKET_LEN (6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic put(input int p, input logic [31:0] v);
    bus.data_in[p*DW +: DW] = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.valid_in  = '0;
    bus.ready_out = 1'b1;
    bus.data_in   = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.valid_in  = '0;
    bus.ready_out = 1'b1;
    bus.data_in   = '0;
    rst = 1'b1;
    #2;
    checks++;
    if ({bus.ready_in, bus.valid_out, bus.data_out} !== 37'h0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b v=%b d=%h expected 0",
               bus.ready_in, bus.valid_out, bus.data_out);
    end
    checks++;
    if ({bus.grant_valid, bus.grant_idx, bus.packets_sent} !== 19'h0) begin
      errors++;
      $display("FAIL reset_state: got gv=%b gi=%0d ps=%0d expected 0",
               bus.grant_valid, bus.grant_idx, bus.packets_sent);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [31:0] fl [6];
    fl = '{32'h05, 32'h11, 32'h22, 32'h33, 32'h44, 32'h55};
    put(2, fl[0]);
    bus.valid_in = 4'b0100;
    #1;
    checks++;
    if (bus.grant_valid !== 1'b0 || bus.valid_out !== 1'b0) begin
      errors++;
      $display("FAIL single_bubble: got gv=%b v=%b expected 0 0",
               bus.grant_valid, bus.valid_out);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      put(2, fl[k]);
      #1;
      checks++;
      if (bus.grant_valid !== 1'b1 || bus.grant_idx !== 2'd2) begin
        errors++;
        $display("FAIL single_grant[%0d]: got gv=%b gi=%0d expected 1 2",
                 k, bus.grant_valid, bus.grant_idx);
      end
      checks++;
      if (bus.valid_out !== 1'b1 || bus.data_out !== fl[k]) begin
        errors++;
        $display("FAIL single_flit[%0d]: got v=%b d=%h expected 1 %h",
                 k, bus.valid_out, bus.data_out, fl[k]);
      end
      checks++;
      if (bus.ready_in !== 4'b0100) begin
        errors++;
        $display("FAIL single_ready[%0d]: got %b expected 0100",
                 k, bus.ready_in);
      end
      if (k == 0) begin
        checks++;
        if (flit_dest(bus.data_out) !== 4'h5) begin
          errors++;
          $display("FAIL single_dest: got %h expected 5",
                   flit_dest(bus.data_out));
        end
      end
    end
    @(negedge clk);
    bus.valid_in = '0;
    #1;
    checks++;
    if (bus.grant_valid !== 1'b0 || bus.packets_sent !== 16'd1) begin
      errors++;
      $display("FAIL single_end: got gv=%b ps=%0d expected 0 1",
               bus.grant_valid, bus.packets_sent);
    end
    checks++;
    if (dut.rr_ptr !== 2'd3) begin
      errors++;
      $display("FAIL single_rrptr: got %0d expected 3", dut.rr_ptr);
    end
  endtask

  task automatic test_round_robin();
    int cnt [4];
    int order [5];
    int pkt, ph;
    logic [31:0] exp_d;
    cnt   = '{0, 0, 0, 0};
    order = '{0, 1, 2, 3, 0};
    do_reset();
    bus.valid_in = 4'hF;
    for (int c = 0; c < 35; c++) begin
      if (c != 0) @(negedge clk);
      for (int p = 0; p < N; p++)
        put(p, {8'(p), 24'(cnt[p])});
      #1;
      pkt = c / 7;
      ph  = c % 7;
      if (ph == 0) begin
        checks++;
        if (bus.grant_valid !== 1'b0 || bus.valid_out !== 1'b0) begin
          errors++;
          $display("FAIL rr_bubble[%0d]: got gv=%b v=%b expected 0 0",
                   c, bus.grant_valid, bus.valid_out);
        end
      end else begin
        exp_d = {8'(order[pkt]), 24'((pkt / 4) * 6 + ph - 1)};
        checks++;
        if (bus.grant_idx !== 2'(order[pkt])) begin
          errors++;
          $display("FAIL rr_grant[%0d]: got %0d expected %0d",
                   c, bus.grant_idx, order[pkt]);
        end
        checks++;
        if (bus.valid_out !== 1'b1 || bus.data_out !== exp_d) begin
          errors++;
          $display("FAIL rr_flit[%0d]: got v=%b d=%h expected 1 %h",
                   c, bus.valid_out, bus.data_out, exp_d);
        end
      end
      for (int p = 0; p < N; p++)
        if (bus.ready_in[p] && bus.valid_in[p]) cnt[p]++;
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.packets_sent !== 16'd5) begin
      errors++;
      $display("FAIL rr_count: got %0d expected 5", bus.packets_sent);
    end
  endtask

  task automatic test_backpressure();
    logic pat [9];
    int   expi [9];
    int   idx;
    pat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    expi = '{0, 1, 1, 1, 2, 2, 3, 4, 5};
    idx  = 0;
    do_reset();
    put(1, 32'h100);
    bus.valid_in = 4'b0010;
    for (int j = 0; j < 9; j++) begin
      @(negedge clk);
      bus.ready_out = pat[j];
      put(1, 32'h100 + 32'(idx));
      #1;
      checks++;
      if (bus.valid_out !== 1'b1 ||
          bus.data_out !== 32'h100 + 32'(expi[j])) begin
        errors++;
        $display("FAIL bp_flit[%0d]: got v=%b d=%h expected 1 %h",
                 j, bus.valid_out, bus.data_out, 32'h100 + 32'(expi[j]));
      end
      checks++;
      if (bus.ready_in !== {2'b00, pat[j], 1'b0}) begin
        errors++;
        $display("FAIL bp_ready[%0d]: got %b expected %b",
                 j, bus.ready_in, {2'b00, pat[j], 1'b0});
      end
      if (pat[j]) idx++;
    end
    @(negedge clk);
    bus.ready_out = 1'b1;
    bus.valid_in  = '0;
    #1;
    checks++;
    if (bus.grant_valid !== 1'b0 || bus.packets_sent !== 16'd1) begin
      errors++;
      $display("FAIL bp_end: got gv=%b ps=%0d expected 0 1",
               bus.grant_valid, bus.packets_sent);
    end
  endtask

  task automatic test_drop_valid();
    logic v0 [9];
    int   expk [9];
    int   k;
    v0   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    expk = '{0, 1, 2, 0, 0, 0, 3, 4, 5};
    k    = 0;
    do_reset();
    put(0, 32'hA0);
    put(3, 32'hD0);
    bus.valid_in = 4'b1001;
    for (int j = 0; j < 9; j++) begin
      @(negedge clk);
      bus.valid_in[0] = v0[j];
      put(0, 32'hA0 + 32'(k));
      #1;
      checks++;
      if (bus.ready_in !== 4'b0001 || bus.grant_idx !== 2'd0) begin
        errors++;
        $display("FAIL drop_lock[%0d]: got rdy=%b gi=%0d expected 0001 0",
                 j, bus.ready_in, bus.grant_idx);
      end
      checks++;
      if (v0[j]) begin
        if (bus.valid_out !== 1'b1 ||
            bus.data_out !== 32'hA0 + 32'(expk[j])) begin
          errors++;
          $display("FAIL drop_flit[%0d]: got v=%b d=%h expected 1 %h",
                   j, bus.valid_out, bus.data_out, 32'hA0 + 32'(expk[j]));
        end
      end else begin
        if (bus.valid_out !== 1'b0 || bus.data_out !== 32'h0) begin
          errors++;
          $display("FAIL drop_gap[%0d]: got v=%b d=%h expected 0 0",
                   j, bus.valid_out, bus.data_out);
        end
      end
      if (v0[j]) k++;
    end
    @(negedge clk);
    bus.valid_in[0] = 1'b0;
    #1;
    checks++;
    if (bus.grant_valid !== 1'b0 || bus.packets_sent !== 16'd1) begin
      errors++;
      $display("FAIL drop_end: got gv=%b ps=%0d expected 0 1",
               bus.grant_valid, bus.packets_sent);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.grant_idx !== 2'd3 || bus.ready_in !== 4'b1000 ||
        bus.data_out !== 32'hD0) begin
      errors++;
      $display("FAIL drop_next: got gi=%0d rdy=%b d=%h expected 3 1000 d0",
               bus.grant_idx, bus.ready_in, bus.data_out);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.valid_in = 4'b0100;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      put(2, 32'h200 + 32'(k));
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.packets_sent !== 16'd1 || dut.rr_ptr !== 2'd3) begin
      errors++;
      $display("FAIL ar_first: got ps=%0d ptr=%0d expected 1 3",
               bus.packets_sent, dut.rr_ptr);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      put(2, 32'h300 + 32'(k));
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.valid_out !== 1'b1 || bus.grant_idx !== 2'd2) begin
      errors++;
      $display("FAIL ar_locked: got v=%b gi=%0d expected 1 2",
               bus.valid_out, bus.grant_idx);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.ready_in !== 4'b0 || bus.valid_out !== 1'b0 ||
        bus.data_out !== 32'h0) begin
      errors++;
      $display("FAIL ar_outputs: got rdy=%b v=%b d=%h expected 0 0 0",
               bus.ready_in, bus.valid_out, bus.data_out);
    end
    checks++;
    if (bus.grant_valid !== 1'b0 || bus.packets_sent !== 16'd0 ||
        bus.grant_idx !== 2'd0) begin
      errors++;
      $display("FAIL ar_state: got gv=%b ps=%0d gi=%0d expected 0 0 0",
               bus.grant_valid, bus.packets_sent, bus.grant_idx);
    end
    #1;
    rst = 1'b0;
    bus.valid_in = 4'b0101;
    @(negedge clk);
    #1;
    checks++;
    if (bus.grant_valid !== 1'b0) begin
      errors++;
      $display("FAIL ar_idle: got gv=%b expected 0", bus.grant_valid);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.grant_valid !== 1'b1 || bus.grant_idx !== 2'd0) begin
      errors++;
      $display("FAIL ar_regrant: got gv=%b gi=%0d expected 1 0",
               bus.grant_valid, bus.grant_idx);
    end
  endtask

  task automatic test_alternate();
    logic [1:0] exp_g;
    do_reset();
    put(0, 32'hF0);
    put(3, 32'hF3);
    bus.valid_in = 4'b1001;
    for (int c = 0; c < 28; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      if (c % 7 == 1) begin
        exp_g = ((c / 7) % 2 == 1) ? 2'd3 : 2'd0;
        checks++;
        if (bus.grant_valid !== 1'b1 || bus.grant_idx !== exp_g) begin
          errors++;
          $display("FAIL alt_grant[%0d]: got gv=%b gi=%0d expected 1 %0d",
                   c, bus.grant_valid, bus.grant_idx, exp_g);
        end
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.packets_sent !== 16'd4) begin
      errors++;
      $display("FAIL alt_count: got %0d expected 4", bus.packets_sent);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_drop_valid();
    test_async_reset();
    test_alternate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
